// File: rtl/alu_pkg.sv
// alu_pkg
//   Shared types and constants for the ALU serial transmit path.
//   tx_state_t           : frame FSM states
//   ALU_DATA_W           : ALU result width
//   ALU_SER_CLKS_PER_BIT : default serial bit period in clk cycles
package alu_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int ALU_DATA_W           = 8;
  localparam int ALU_SER_CLKS_PER_BIT = 4;

endpackage

// File: rtl/bit_timer.sv
// bit_timer
//   Bit-period timer. Counts 0..CLKS_PER_BIT-1 while run is high and
//   pulses tick on the last count, which is the cycle the caller
//   should advance. Held at zero whenever run is low.
//   clk   : system clock
//   reset : synchronous, active-high
//   run   : enable; low clears the counter
//   tick  : high in the final cycle of each bit period
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || !run) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/alu_serial_tx.sv
// alu_serial_tx
//   Serial frame transmitter: start bit, DATA_W data bits LSB-first,
//   optional even-parity bit, stop bit. One byte per valid/ready accept.
//   clk      : system clock
//   reset    : synchronous, active-high
//   in_valid : in_data holds a byte to send
//   in_data  : byte to send, sampled only on accept
//   in_ready : idle, can accept a byte
//   tx       : serial line, idles high
//   busy     : frame in progress
//   done     : one-cycle pulse on the first idle cycle after a frame
//
//   state  | meaning
//   IDLE   | line high, waiting for in_valid
//   START  | start bit (low)
//   DATA   | data bits, LSB first
//   PARITY | even parity of the latched byte
//   STOP   | stop bit (high)
module alu_serial_tx
  import alu_pkg::*;
#(
  parameter int DATA_W       = ALU_DATA_W,
  parameter int CLKS_PER_BIT = ALU_SER_CLKS_PER_BIT,
  parameter int PARITY_EN    = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic [BIT_W-1:0]  bit_cnt;
  logic              parity;
  logic              tick;
  logic              run;

  // Timer runs in every frame state so its count starts at zero on the
  // first start-bit cycle, and wraps to zero on the final stop tick.
  assign run        = (state != IDLE);
  assign shift_next = shift_reg >> 1;

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk  (clk),
    .reset(reset),
    .run  (run),
    .tick (tick)
  );

  // tx is loaded with the next state's line value on the transition edge,
  // so the line is fully registered and changes with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      bit_cnt   <= '0;
      parity    <= 1'b0;
      tx        <= 1'b1;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shift_reg <= in_data;
            parity    <= ^in_data;
            bit_cnt   <= '0;
            state     <= START;
            tx        <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            state   <= DATA;
            tx      <= shift_reg[0];
            bit_cnt <= '0;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              if (PARITY_EN != 0) begin
                state <= PARITY;
                tx    <= parity;
              end else begin
                state <= STOP;
                tx    <= 1'b1;
              end
            end else begin
              shift_reg <= shift_next;
              tx        <= shift_next[0];
              bit_cnt   <= bit_cnt + BIT_W'(1);
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state <= STOP;
            tx    <= 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            state    <= IDLE;
            tx       <= 1'b1;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          in_ready <= 1'b1;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
